seq_alu: RTL and testbench

Parametrised multi-cycle successor to the single-cycle N-bit ALU.
- Keeps the ADD/SUB/AND/OR encodings.
- Adds XOR, shifts, set-less-than, and iterative unsigned multiply and divide.
- Uses valid/ready handshakes on input and output, so the EX stage can stall on long operations.
- Sits between the decode/operand-read stage and writeback.

---
 rtl/seq_alu.sv | 201 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith/shift/compare ops plus
// iterative unsigned multiply; iterative divide is built only when SEQ_ALU_DIV_EN is defined.
module seq_alu #(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [3:0]   sel_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] c_o,
  output logic         zero_o,
  output logic         illegal_o
);

  localparam int unsigned SHW  = $clog2(N);
  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntInit = CntW'(N);

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpXor   = 4'b0011;
  localparam logic [3:0] OpSll   = 4'b0100;
  localparam logic [3:0] OpSrl   = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSra   = 4'b0111;
  localparam logic [3:0] OpSlt   = 4'b1000;
  localparam logic [3:0] OpSltu  = 4'b1001;
  localparam logic [3:0] OpMul   = 4'b1010;
  localparam logic [3:0] OpMulhu = 4'b1011;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OpDivu  = 4'b1100;
  localparam logic [3:0] OpRemu  = 4'b1101;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    acc_q, acc_d;   // product high half / partial remainder
  logic [N-1:0]    mq_q, mq_d;     // multiplier -> product low half / dividend -> quotient
  logic [N-1:0]    b_q, b_d;
  logic            hi_q, hi_d;     // result comes from acc (MULHU/REMU) rather than mq
  logic [N-1:0]    c_q, c_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
`ifdef SEQ_ALU_DIV_EN
  logic            div_q, div_d;
`endif

  logic [SHW-1:0] shamt;
  logic [N-1:0]   alu_res;
  logic           sc_illegal;
  logic           sc_multi;

  assign shamt = b_i[SHW-1:0];

  always_comb begin
    alu_res    = '0;
    sc_illegal = 1'b0;
    sc_multi   = 1'b0;
    case (sel_i)
      OpAnd:  alu_res = a_i & b_i;
      OpOr:   alu_res = a_i | b_i;
      OpAdd:  alu_res = a_i + b_i;
      OpXor:  alu_res = a_i ^ b_i;
      OpSll:  alu_res = a_i << shamt;
      OpSrl:  alu_res = a_i >> shamt;
      OpSub:  alu_res = a_i + ~b_i + {{(N-1){1'b0}}, 1'b1};
      OpSra:  alu_res = $unsigned($signed(a_i) >>> shamt);
      OpSlt:  alu_res = {{(N-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OpSltu: alu_res = {{(N-1){1'b0}}, a_i < b_i};
      OpMul, OpMulhu: sc_multi = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OpDivu, OpRemu: sc_multi = 1'b1;
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration of the shared multi-cycle datapath
  logic [N:0]   mul_sum;
  logic [N-1:0] step_acc, step_mq;
`ifdef SEQ_ALU_DIV_EN
  logic [N:0]   rem_sh;
  logic [N-1:0] rem_diff;
  logic         rem_ge;
`endif

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
    step_acc = mul_sum[N:1];
    step_mq  = {mul_sum[0], mq_q[N-1:1]};
`ifdef SEQ_ALU_DIV_EN
    rem_sh   = {acc_q, mq_q[N-1]};
    rem_diff = rem_sh[N-1:0] - b_q;
    rem_ge   = rem_sh >= {1'b0, b_q};
    if (div_q) begin
      // Divisor 0 always "fits": quotient saturates to all ones, remainder collects a
      step_acc = rem_ge ? rem_diff : rem_sh[N-1:0];
      step_mq  = {mq_q[N-2:0], rem_ge};
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    b_d       = b_q;
    hi_d      = hi_q;
    c_d       = c_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef SEQ_ALU_DIV_EN
    div_d     = div_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (sc_multi) begin
            acc_d   = '0;
            mq_d    = a_i;
            b_d     = b_i;
            hi_d    = sel_i[0];
            cnt_d   = CntInit;
            state_d = StBusy;
`ifdef SEQ_ALU_DIV_EN
            div_d   = sel_i[2];
`endif
          end else begin
            // alu_res is already 0 for illegal codes
            c_d       = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = sc_illegal;
            state_d   = StDone;
          end
        end
      end
      StBusy: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          c_d       = hi_q ? step_acc : step_mq;
          zero_d    = ((hi_q ? step_acc : step_mq) == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      b_q       <= '0;
      hi_q      <= 1'b0;
      c_q       <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      c_q       <= c_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef SEQ_ALU_DIV_EN
      div_q     <= div_d;
`endif
    end
  end

  assign ready_o   = (state_q == StIdle);
  assign valid_o   = (state_q == StDone);
  assign c_o       = c_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (N=32): directed cases plus random ops against a
// plain-arithmetic reference model.
module tb_seq_alu;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic [3:0]    sel_i;
  logic [N-1:0]  a_i;
  logic [N-1:0]  b_i;
  logic          valid_o;
  logic          ready_i;
  logic [N-1:0]  c_o;
  logic          zero_o;
  logic          illegal_o;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.N(N)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .sel_i     (sel_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .c_o       (c_o),
    .zero_o    (zero_o),
    .illegal_o (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, result}
  function automatic logic [N:0] model(input logic [3:0] sel, input logic [N-1:0] a,
                                       input logic [N-1:0] b);
    logic [63:0] p;
    int          sh;
    p  = {32'b0, a} * {32'b0, b};
    sh = int'(b % N);
    case (sel)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0011: return {1'b0, a ^ b};
      4'b0100: return {1'b0, a << sh};
      4'b0101: return {1'b0, a >> sh};
      4'b0110: return {1'b0, a - b};
      4'b0111: return {1'b0, $unsigned($signed(a) >>> sh)};
      4'b1000: return {1'b0, 31'b0, ($signed(a) < $signed(b))};
      4'b1001: return {1'b0, 31'b0, (a < b)};
      4'b1010: return {1'b0, p[31:0]};
      4'b1011: return {1'b0, p[63:32]};
`ifdef SEQ_ALU_DIV_EN
      4'b1100: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
      4'b1101: return {1'b0, (b == 0) ? a : a % b};
`endif
      default: return {1'b1, 32'b0};
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] sel);
    if (sel == 4'b1010 || sel == 4'b1011) return N + 1;
`ifdef SEQ_ALU_DIV_EN
    if (sel == 4'b1100 || sel == 4'b1101) return N + 1;
`endif
    return 1;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input string tag, input logic [3:0] sel, input logic [N-1:0] a,
                        input logic [N-1:0] b, input int hold);
    logic [N:0] m;
    int         lat;
    m = model(sel, a, b);
    check({tag, " ready_in"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    sel_i   = sel;
    a_i     = a;
    b_i     = b;
    ready_i = (hold == 0);
    @(posedge clk);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (valid_o) break;
      // Junk on the inputs while busy must be ignored
      valid_i = 1'($urandom);
      sel_i   = 4'($urandom);
      a_i     = $urandom;
      b_i     = $urandom;
    end
    valid_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(sel)));
    check({tag, " c"}, 64'(c_o), 64'(m[N-1:0]));
    check({tag, " zero"}, 64'(zero_o), 64'(m[N-1:0] == 0));
    check({tag, " illegal"}, 64'(illegal_o), 64'(m[N]));
    check({tag, " ready_done"}, 64'(ready_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 64'(valid_o), 64'd1);
      check({tag, " hold_c"}, 64'(c_o), 64'(m[N-1:0]));
      check({tag, " hold_zero"}, 64'(zero_o), 64'(m[N-1:0] == 0));
      check({tag, " hold_ready"}, 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " valid_after"}, 64'(valid_o), 64'd0);
    check({tag, " ready_after"}, 64'(ready_o), 64'd1);
  endtask

  initial begin
    logic [3:0]   rsel;
    logic [N-1:0] ra, rb;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    sel_i   = '0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(negedge clk);
    check("rst valid", 64'(valid_o), 64'd0);
    check("rst ready", 64'(ready_o), 64'd1);
    check("rst c", 64'(c_o), 64'd0);
    check("rst zero", 64'(zero_o), 64'd1);
    check("rst illegal", 64'(illegal_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub", 4'b0110, 32'd5, 32'd7, 0);
    run_op("slt", 4'b1000, 32'hFFFF_FFFE, 32'd1, 0);
    run_op("sltu", 4'b1001, 32'hFFFF_FFFE, 32'd1, 0);
    run_op("sra", 4'b0111, 32'h8000_0000, 32'h24, 0);
    run_op("xor", 4'b0011, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 0);
    run_op("sll", 4'b0100, 32'h0000_0003, 32'd31, 0);
    run_op("mul", 4'b1010, 32'h0001_0000, 32'h0001_0000, 0);
    run_op("mulhu", 4'b1011, 32'h0001_0000, 32'h0001_0000, 0);
    run_op("mul_zero", 4'b1010, 32'd0, 32'hDEAD_BEEF, 0);
    run_op("divu", 4'b1100, 32'd100, 32'd7, 0);
    run_op("remu", 4'b1101, 32'd100, 32'd7, 0);
    run_op("divu0", 4'b1100, 32'd9, 32'd0, 0);
    run_op("remu0", 4'b1101, 32'd9, 32'd0, 0);
    run_op("and_bp", 4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 10);

    // Abort a multiply with reset
    valid_i = 1'b1;
    sel_i   = 4'b1010;
    a_i     = 32'h1234_5678;
    b_i     = 32'h9ABC_DEF0;
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    check("busy ready", 64'(ready_o), 64'd0);
    check("busy valid", 64'(valid_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    check("abort valid", 64'(valid_o), 64'd0);
    check("abort ready", 64'(ready_o), 64'd1);
    check("abort c", 64'(c_o), 64'd0);
    check("abort zero", 64'(zero_o), 64'd1);
    check("abort illegal", 64'(illegal_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_op("or_after_rst", 4'b0001, 32'hF0, 32'h0F, 0);
    run_op("illegal_1111", 4'b1111, 32'h1234_5678, 32'h1, 0);

    for (int i = 0; i < 60; i++) begin
      rsel = 4'($urandom_range(0, 15));
      ra   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op("rand", rsel, ra, rb, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
